// File: rtl/frost_boot_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding,
// status response bytes and a byte-sum helper used by readback verification.
package frost_boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        VERIFY,
        RESP,
        RUN
    } boot_state_e;

    localparam logic [7:0] RSP_OK      = 8'h4B;
    localparam logic [7:0] RSP_ERR     = 8'h45;
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;
    localparam logic [7:0] RSP_VERIFY  = 8'h56;

    function automatic logic [7:0] byte_sum(input logic [31:0] word);
        return word[7:0] + word[15:8] + word[23:16] + word[31:24];
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Collects payload bytes little-endian into 32-bit words and keeps the running
// mod-256 payload checksum; o_word_done flags the byte that completes a word.
module boot_word_assembler (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_done,
    output logic [31:0] o_word,
    output logic [7:0]  o_checksum
);

    logic [31:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        if (i_clear) begin
            shift_d = '0;
            cnt_d   = '0;
            chk_d   = '0;
        end else if (i_byte_valid) begin
            shift_d = {i_byte, shift_q[31:8]};
            cnt_d   = cnt_q + 2'd1;
            chk_d   = chk_q + i_byte;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
        end
    end

    // The completed word is presented combinationally so the loader can register it
    // while the shifter is already free to take the next word's first byte.
    assign o_word      = {i_byte, shift_q[31:8]};
    assign o_word_done = i_byte_valid && !i_clear && (cnt_q == 2'd3);
    assign o_checksum  = chk_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: frames SYNC/LEN/payload/CHK from the RX stream, programs
// instruction memory and releases the CPU after a good load. Optional readback
// check of the programmed image is enabled by BOOT_READBACK_VERIFY_EN.
module uart_boot_loader
    import frost_boot_pkg::*;
#(
    parameter int          MEM_SIZE_BYTES = 2**17,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 2**24,
    parameter logic [7:0]  SYNC_BYTE      = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_instr_mem_en,
    output logic [3:0]  o_instr_mem_we,
    output logic [31:0] o_instr_mem_addr,
    output logic [31:0] o_instr_mem_wrdata,
    input  logic [31:0] i_instr_mem_rddata,
    input  logic        i_boot_req,
    output logic        o_cpu_rst_n,
    output logic        o_busy
);

    localparam logic [31:0] MAX_WORDS  = 32'(MEM_SIZE_BYTES / 4);
    localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 2);

    boot_state_e state_q, state_d;
    boot_state_e resp_next_q, resp_next_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        en_q, en_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wrdata_q, wrdata_d;

    logic        rx_accept;
    logic [15:0] len_rx;
    logic [31:0] word_addr;
    logic        asm_clear;
    logic        asm_valid;
    logic        asm_word_done;
    logic [31:0] asm_word;
    logic [7:0]  asm_chk;
    logic        resp_go;
    logic [7:0]  resp_code;
    boot_state_e resp_to;

`ifdef BOOT_READBACK_VERIFY_EN
    logic [7:0]  vsum_q, vsum_d;
    logic        rd_valid_q, rd_valid_d;
`else
    logic        unused_rddata;
    assign unused_rddata = ^i_instr_mem_rddata;
`endif

    assign o_rx_ready = (state_q == IDLE) || (state_q == LEN0) || (state_q == LEN1) ||
                        (state_q == DATA) || (state_q == CHK);
    assign rx_accept  = i_rx_valid && o_rx_ready;
    assign len_rx     = {i_rx_data, len_lo_q};
    assign word_addr  = BASE_ADDR + {14'd0, idx_q, 2'b00};

    boot_word_assembler u_assembler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clear      (asm_clear),
        .i_byte_valid (asm_valid),
        .i_byte       (i_rx_data),
        .o_word_done  (asm_word_done),
        .o_word       (asm_word),
        .o_checksum   (asm_chk)
    );

    always_comb begin
        state_d     = state_q;
        resp_next_d = resp_next_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        cpu_rst_n_d = cpu_rst_n_q;
        en_d        = 1'b0;
        we_d        = 4'h0;
        addr_d      = addr_q;
        wrdata_d    = wrdata_q;
        asm_clear   = 1'b0;
        asm_valid   = 1'b0;
        resp_go     = 1'b0;
        resp_code   = RSP_ERR;
        resp_to     = IDLE;
`ifdef BOOT_READBACK_VERIFY_EN
        vsum_d      = vsum_q;
        rd_valid_d  = en_q && (we_q == 4'h0) && (state_q == VERIFY);
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rx_accept && (i_rx_data == SYNC_BYTE)) begin
                    state_d   = LEN0;
                    busy_d    = 1'b1;
                    asm_clear = 1'b1;
                    idx_d     = '0;
                end
            end
            LEN0, LEN1, DATA, CHK: begin
                timer_d = rx_accept ? '0 : timer_q + 32'd1;
                if (rx_accept) begin
                    case (state_q)
                        LEN0: begin
                            len_lo_d = i_rx_data;
                            state_d  = LEN1;
                        end
                        LEN1: begin
                            len_d = len_rx;
                            if ((len_rx == 16'd0) || ({16'd0, len_rx} > MAX_WORDS)) begin
                                resp_go = 1'b1;
                            end else begin
                                state_d = DATA;
                            end
                        end
                        DATA: begin
                            asm_valid = 1'b1;
                            if (asm_word_done) begin
                                en_d     = 1'b1;
                                we_d     = 4'hF;
                                addr_d   = word_addr;
                                wrdata_d = asm_word;
                                idx_d    = idx_q + 16'd1;
                                if (idx_q == len_q - 16'd1) begin
                                    state_d = CHK;
                                end
                            end
                        end
                        CHK: begin
                            if (i_rx_data == asm_chk) begin
`ifdef BOOT_READBACK_VERIFY_EN
                                state_d = VERIFY;
                                idx_d   = '0;
                                vsum_d  = '0;
`else
                                resp_go   = 1'b1;
                                resp_code = RSP_OK;
                                resp_to   = RUN;
`endif
                            end else begin
                                resp_go = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end else if (timer_q == TIMER_LAST) begin
                    resp_go   = 1'b1;
                    resp_code = RSP_TIMEOUT;
                end
            end
`ifdef BOOT_READBACK_VERIFY_EN
            // Reads are issued on alternate cycles; each returned word's bytes are
            // re-summed and the total must reproduce the frame checksum.
            VERIFY: begin
                if (rd_valid_q) begin
                    vsum_d = vsum_q + byte_sum(i_instr_mem_rddata);
                end
                if (rd_valid_q && (idx_q == len_q)) begin
                    resp_go = 1'b1;
                    if (vsum_d == asm_chk) begin
                        resp_code = RSP_OK;
                        resp_to   = RUN;
                    end else begin
                        resp_code = RSP_VERIFY;
                    end
                end else if (!en_q && (idx_q != len_q)) begin
                    en_d   = 1'b1;
                    addr_d = word_addr;
                    idx_d  = idx_q + 16'd1;
                end
            end
`endif
            RESP: begin
                if (i_tx_ready) begin
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = resp_next_q;
                    if (resp_next_q == RUN) begin
                        cpu_rst_n_d = 1'b1;
                    end
                end
            end
            RUN: ;
            default: state_d = IDLE;
        endcase

        if (resp_go) begin
            state_d     = RESP;
            tx_data_d   = resp_code;
            tx_valid_d  = 1'b1;
            resp_next_d = resp_to;
        end

        // A boot request overrides everything: drop any queued write or response.
        if (i_boot_req) begin
            state_d     = IDLE;
            cpu_rst_n_d = 1'b0;
            tx_valid_d  = 1'b0;
            busy_d      = 1'b0;
            en_d        = 1'b0;
            we_d        = 4'h0;
            addr_d      = addr_q;
            wrdata_d    = wrdata_q;
            idx_d       = '0;
            timer_d     = '0;
            asm_clear   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            resp_next_q <= IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            timer_q     <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 4'h0;
            addr_q      <= '0;
            wrdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            resp_next_q <= resp_next_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            en_q        <= en_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wrdata_q    <= wrdata_d;
        end
    end

`ifdef BOOT_READBACK_VERIFY_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vsum_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            vsum_q     <= vsum_d;
            rd_valid_q <= rd_valid_d;
        end
    end
`endif

    assign o_tx_data          = tx_data_q;
    assign o_tx_valid         = tx_valid_q;
    assign o_busy             = busy_q;
    assign o_cpu_rst_n        = cpu_rst_n_q;
    assign o_instr_mem_en     = en_q;
    assign o_instr_mem_we     = we_q;
    assign o_instr_mem_addr   = addr_q;
    assign o_instr_mem_wrdata = wrdata_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: expected memory writes and status bytes
// are queued as frames are driven and checked as the loader produces them.
module tb_uart_boot_loader;

    logic        i_clk;
    logic        i_rst_n;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_instr_mem_en;
    logic [3:0]  o_instr_mem_we;
    logic [31:0] o_instr_mem_addr;
    logic [31:0] o_instr_mem_wrdata;
    logic [31:0] i_instr_mem_rddata;
    logic        i_boot_req;
    logic        o_cpu_rst_n;
    logic        o_busy;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] writeQ[$];
    logic [7:0]  respQ[$];

    uart_boot_loader #(
        .MEM_SIZE_BYTES (2**17),
        .BASE_ADDR      (32'h0),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'h5A)
    ) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_rx_data          (i_rx_data),
        .i_rx_valid         (i_rx_valid),
        .o_rx_ready         (o_rx_ready),
        .o_tx_data          (o_tx_data),
        .o_tx_valid         (o_tx_valid),
        .i_tx_ready         (i_tx_ready),
        .o_instr_mem_en     (o_instr_mem_en),
        .o_instr_mem_we     (o_instr_mem_we),
        .o_instr_mem_addr   (o_instr_mem_addr),
        .o_instr_mem_wrdata (o_instr_mem_wrdata),
        .i_instr_mem_rddata (i_instr_mem_rddata),
        .i_boot_req         (i_boot_req),
        .o_cpu_rst_n        (o_cpu_rst_n),
        .o_busy             (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] sumBytes(input logic [31:0] w);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 4; i++) s = s + w[8*i +: 8];
        return s;
    endfunction

    // Every programming-port access must match the next queued write.
    always @(negedge i_clk) begin
        if (i_rst_n && o_instr_mem_en) begin
            if (writeQ.size() == 0) begin
                checkOutput("unexpected_write_we", {28'd0, o_instr_mem_we}, 32'd0);
            end else begin
                logic [63:0] exp;
                exp = writeQ.pop_front();
                checkOutput("write_we", {28'd0, o_instr_mem_we}, 32'hF);
                checkOutput("write_addr", o_instr_mem_addr, exp[63:32]);
                checkOutput("write_data", o_instr_mem_wrdata, exp[31:0]);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("rx_ready_wait", {31'd0, o_rx_ready}, 32'd1);
        @(negedge i_clk);
    endtask

    task automatic sendLoad(input logic [31:0] w0, input logic [31:0] w1, input bit corrupt);
        logic [7:0] chk;
        chk = sumBytes(w0) + sumBytes(w1);
        if (corrupt) chk = ~chk;
        writeQ.push_back({32'h0, w0});
        writeQ.push_back({32'h4, w1});
        respQ.push_back(corrupt ? 8'h45 : 8'h4B);
        applyStimulus(8'h5A);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        for (int i = 0; i < 4; i++) applyStimulus(w0[8*i +: 8]);
        for (int i = 0; i < 4; i++) applyStimulus(w1[8*i +: 8]);
        applyStimulus(chk);
        i_rx_valid = 1'b0;
    endtask

    task automatic waitResp(input int holdCycles);
        int n;
        logic [7:0] exp;
        n = 0;
        while (!o_tx_valid && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        exp = (respQ.size() != 0) ? respQ.pop_front() : 8'h00;
        checkOutput("tx_valid", {31'd0, o_tx_valid}, 32'd1);
        checkOutput("tx_data", {24'd0, o_tx_data}, {24'd0, exp});
        checkOutput("cpu_held_in_resp", {31'd0, o_cpu_rst_n}, 32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge i_clk);
            checkOutput("tx_hold", {23'd0, o_tx_valid, o_tx_data}, {23'd0, 1'b1, exp});
        end
        i_tx_ready = 1'b1;
        @(negedge i_clk);
        i_tx_ready = 1'b0;
        checkOutput("tx_drop", {31'd0, o_tx_valid}, 32'd0);
        checkOutput("busy_after_resp", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic pulseBootReq();
        i_boot_req = 1'b1;
        @(negedge i_clk);
        i_boot_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation hung");
    end

    initial begin
        int cycles;
        i_rst_n            = 1'b0;
        i_rx_data          = 8'h00;
        i_rx_valid         = 1'b0;
        i_tx_ready         = 1'b0;
        i_instr_mem_rddata = 32'h0;
        i_boot_req         = 1'b0;
        #1;
        checkOutput("rst_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput("rst_tx_valid", {31'd0, o_tx_valid}, 32'd0);
        checkOutput("rst_tx_data", {24'd0, o_tx_data}, 32'd0);
        checkOutput("rst_mem_en", {31'd0, o_instr_mem_en}, 32'd0);
        checkOutput("rst_mem_we", {28'd0, o_instr_mem_we}, 32'd0);
        checkOutput("rst_mem_addr", o_instr_mem_addr, 32'd0);
        checkOutput("rst_mem_wrdata", o_instr_mem_wrdata, 32'd0);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        $display("[TB] garbage then good load");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h13);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("garbage_busy", {31'd0, o_busy}, 32'd0);
        sendLoad(32'h44332211, 32'hDDCCBBAA, 1'b0);
        waitResp(0);
        checkOutput("run_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd1);
        checkOutput("run_rx_ready", {31'd0, o_rx_ready}, 32'd0);

        $display("[TB] boot request in RUN");
        pulseBootReq();
        checkOutput("bootreq_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput("bootreq_rx_ready", {31'd0, o_rx_ready}, 32'd1);

        $display("[TB] bad checksum");
        sendLoad(32'h44332211, 32'hDDCCBBAA, 1'b1);
        waitResp(0);
        checkOutput("badchk_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);

        $display("[TB] length bounds");
        respQ.push_back(8'h45);
        applyStimulus(8'h5A);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        i_rx_valid = 1'b0;
        waitResp(0);
        respQ.push_back(8'h45);
        applyStimulus(8'h5A);
        applyStimulus(8'h01);
        applyStimulus(8'h80);
        i_rx_valid = 1'b0;
        waitResp(0);
        applyStimulus(8'h5A);
        applyStimulus(8'h00);
        applyStimulus(8'h80);
        i_rx_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("max_len_busy", {31'd0, o_busy}, 32'd1);
        checkOutput("max_len_no_tx", {31'd0, o_tx_valid}, 32'd0);
        checkOutput("max_len_rx_ready", {31'd0, o_rx_ready}, 32'd1);
        pulseBootReq();
        checkOutput("max_len_abort_busy", {31'd0, o_busy}, 32'd0);

        $display("[TB] timeout");
        respQ.push_back(8'h54);
        applyStimulus(8'h5A);
        applyStimulus(8'h01);
        applyStimulus(8'h00);
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        i_rx_valid = 1'b0;
        cycles = 0;
        while (!o_tx_valid && cycles < 300) begin
            @(negedge i_clk);
            cycles++;
        end
        checkOutput("timeout_cycle", cycles, 32'd99);
        waitResp(0);
        checkOutput("timeout_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);
        checkOutput("timeout_idle_ready", {31'd0, o_rx_ready}, 32'd1);

        $display("[TB] boot request mid-DATA");
        writeQ.push_back({32'h0, 32'h78563412});
        applyStimulus(8'h5A);
        applyStimulus(8'h02);
        applyStimulus(8'h00);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'h56);
        applyStimulus(8'h78);
        applyStimulus(8'h9A);
        applyStimulus(8'hBC);
        i_rx_valid = 1'b0;
        pulseBootReq();
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            checkOutput("abort_no_tx", {31'd0, o_tx_valid}, 32'd0);
        end
        checkOutput("abort_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd0);

        $display("[TB] backpressure on response");
        sendLoad(32'hDEADBEEF, 32'h01020304, 1'b0);
        waitResp(50);
        checkOutput("bp_cpu_rst_n", {31'd0, o_cpu_rst_n}, 32'd1);

        repeat (3) @(negedge i_clk);
        checkOutput("writes_outstanding", writeQ.size(), 32'd0);
        checkOutput("resps_outstanding", respQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
